// File: rtl/cube_layer_scanner_if.sv
// Frame handshake and column/layer drive bundle for the LED cube scanner.
// Ports: frame_data/frame_valid/frame_ready carry one whole frame from upstream;
//        sr_data/sr_clk/sr_latch/oe_n drive the column shift chain, layer_en the layer transistors.
// slave modport = scanner side, master modport = upstream/driver side.
interface cube_layer_scanner_if #(
  parameter int N = 8
);
  logic [N*N*N-1:0] frame_data;
  logic             frame_valid;
  logic             frame_ready;
  logic             sr_data;
  logic             sr_clk;
  logic             sr_latch;
  logic [N-1:0]     layer_en;
  logic             oe_n;

  modport slave (
    input  frame_data, frame_valid,
    output frame_ready, sr_data, sr_clk, sr_latch, layer_en, oe_n
  );

  modport master (
    output frame_data, frame_valid,
    input  frame_ready, sr_data, sr_clk, sr_latch, layer_en, oe_n
  );
endinterface

// File: rtl/cube_layer_scanner.sv
// Captures one cube frame and scans it layer by layer: shift N*N column bits, latch, dwell.
// Latency: handshake to first sr_clk rise is 1+SCLK_DIV cycles; frame period N*layer_period+1.
// Backpressure: frame_ready only in IDLE/FETCH, so new frames swap in at whole-frame boundaries.
// Ports: CLOCK_50, rst_n (synchronous, active-low), bus (cube_layer_scanner_if.slave).
// Option: define CUBE_SCAN_BLANK_EN to blank layers and columns outside DWELL.
module cube_layer_scanner #(
  parameter int N        = 8,
  parameter int SCLK_DIV = 2,
  parameter int DWELL    = 5000
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  cube_layer_scanner_if.slave   bus
);

  localparam int NN      = N * N;
  localparam int NBITS   = N * N * N;
  localparam int SHIFT_C = 2 * SCLK_DIV * NN;
  localparam int CNT_MAX = (DWELL > SHIFT_C) ? DWELL : SHIFT_C;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = (NN > 1) ? $clog2(NN) : 1;
  localparam int LW      = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;       // cycle counter within the current bit / latch / dwell
  logic [BW-1:0]      bit_q, bit_d;       // column bit being shifted, counts down
  logic [LW-1:0]      layer_q, layer_d;
  logic [NBITS-1:0]   frame_q, frame_d;
  logic [N-1:0]       en_q, en_d;         // layer most recently latched
  logic               lit_q, lit_d;       // a layer has been latched since reset

  logic [NN-1:0]      layer_bits;
  logic [N-1:0]       layer_onehot;

  assign layer_bits = frame_q[layer_q*NN +: NN];

  always_comb begin
    layer_onehot          = '0;
    layer_onehot[layer_q] = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      layer_q <= '0;
      frame_q <= '0;
      en_q    <= '0;
      lit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      layer_q <= layer_d;
      frame_q <= frame_d;
      en_q    <= en_d;
      lit_q   <= lit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    layer_d = layer_q;
    frame_d = frame_q;
    en_d    = en_q;
    lit_d   = lit_q;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_valid) begin
          frame_d = bus.frame_data;
          layer_d = '0;
          cnt_d   = '0;
          bit_d   = BW'(NN - 1);
          state_d = S_SHIFT;
        end
      end
      S_FETCH: begin
        // Without a pending frame the old one simply repeats.
        if (bus.frame_valid) begin
          frame_d = bus.frame_data;
        end
        cnt_d   = '0;
        bit_d   = BW'(NN - 1);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Low half of each bit period is cnt < SCLK_DIV, high half the rest.
        if (cnt_q == CW'(2 * SCLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d = S_LATCH;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(SCLK_DIV - 1)) begin
          cnt_d   = '0;
          en_d    = layer_onehot;
          lit_d   = 1'b1;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          bit_d = BW'(NN - 1);
          if (layer_q == LW'(N - 1)) begin
            layer_d = '0;
            state_d = S_FETCH;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = S_SHIFT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by rst_n so the scanner never advertises ready while held in reset.
  assign bus.frame_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_FETCH));
  assign bus.sr_data     = (state_q == S_SHIFT) && layer_bits[bit_q];
  assign bus.sr_clk      = (state_q == S_SHIFT) && (cnt_q >= CW'(SCLK_DIV));
  assign bus.sr_latch    = (state_q == S_LATCH);

`ifdef CUBE_SCAN_BLANK_EN
  assign bus.layer_en = (state_q == S_DWELL) ? en_q : '0;
  assign bus.oe_n     = !((state_q == S_DWELL) && lit_q);
`else
  // Previous layer keeps glowing while the next one shifts in.
  assign bus.layer_en = en_q;
  assign bus.oe_n     = !lit_q;
`endif

endmodule

// File: tb/tb_cube_layer_scanner.sv
// Randomised scoreboard bench for cube_layer_scanner (N=2, SCLK_DIV=1, DWELL=4).
// Stimulus pushes one expected record per displayed layer; a negedge monitor pops on each sr_latch fall.
// Reference timing comes from the layer/frame period arithmetic, not from the state machine.
module tb_cube_layer_scanner;
  localparam int N  = 2;
  localparam int S  = 1;
  localparam int D  = 4;
  localparam int NN = N * N;
  localparam int NB = NN * N;
  localparam int LP = 2 * S * NN + S + D;
  localparam int FP = N * LP + 1;

  typedef struct {
    int            s;     // first SHIFT cycle of this layer
    int            fall;  // cycle in which sr_latch is first low again
    logic [NN-1:0] bits;  // layer word, first shifted bit in the MSB
    logic [N-1:0]  en;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  cube_layer_scanner_if #(.N(N)) bus ();

  cube_layer_scanner #(.N(N), .SCLK_DIV(S), .DWELL(D)) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
    chk("schedule", cyc, k);
  endtask

  task automatic push_rep(input int start, input logic [NB-1:0] frame, input int nl);
    exp_t e;
    for (int l = 0; l < nl; l++) begin
      e.s    = start + 1 + l * LP;
      e.fall = e.s + 2 * S * NN + S;
      e.bits = NN'(frame >> (l * NN));
      e.en   = N'(1 << l);
      sbq.push_back(e);
      n_push++;
    end
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_ready"}, bus.frame_ready, 1'b0);
    chk({tag, "_sr_data"}, bus.sr_data, 1'b0);
    chk({tag, "_sr_clk"}, bus.sr_clk, 1'b0);
    chk({tag, "_sr_latch"}, bus.sr_latch, 1'b0);
    chk({tag, "_layer_en"}, bus.layer_en, '0);
    chk({tag, "_oe_n"}, bus.oe_n, 1'b1);
  endtask

  // Frame handshake happened in cycle c0; show nrep repetitions, sometimes offering a new frame mid-scan.
  task automatic run_frames(input int c0, input logic [NB-1:0] f0, input int nrep,
                            output logic [NB-1:0] cur_o);
    logic [NB-1:0] cur;
    logic [NB-1:0] nf;
    int start, fetch, raise;
    bit newf;
    cur = f0;
    for (int r = 0; r < nrep; r++) begin
      start = c0 + r * FP;
      fetch = start + FP;
      push_rep(start, cur, N);
      goto(start + 1);
      bus.frame_valid = 1'b0;
      bus.frame_data  = NB'($urandom);
      newf = (r == 1) || (r >= 2 && $urandom_range(0, 1) == 1);
      if (newf) begin
        raise = start + 2 + $urandom_range(0, FP - 3);
        goto(raise);
        nf = cur ^ NB'($urandom_range(1, (1 << NB) - 1));
        bus.frame_valid = 1'b1;
        bus.frame_data  = nf;
        while (cyc < fetch) begin
          chk("ready_blocked", bus.frame_ready, 1'b0);
          @(posedge clk);
          #1;
        end
        cur = nf;
      end else begin
        goto(fetch);
      end
      chk("ready_fetch", bus.frame_ready, 1'b1);
    end
    cur_o = cur;
  endtask

  initial begin
    logic [NB-1:0] cur;
    logic [NB-1:0] f3;
    int start, fall;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_dark("reset");
    rst_n = 1'b1;
    #1;
    chk("idle_ready", bus.frame_ready, 1'b1);
    chk("idle_layer_en", bus.layer_en, '0);
    bus.frame_data = NB'($urandom);
    goto(2);
    chk("idle_ready_2", bus.frame_ready, 1'b1);
    bus.frame_valid = 1'b1;
    bus.frame_data  = 8'b1001_0110;
    run_frames(2, 8'b1001_0110, 5, cur);

    // One more layer, then reset in the middle of its dwell.
    start = 2 + 5 * FP;
    fall  = start + 1 + 2 * S * NN + S;
    push_rep(start, cur, 1);
    goto(start + 1);
    bus.frame_valid = 1'b0;
    goto(fall + 1);
    rst_n = 1'b0;
    f3 = NB'($urandom);
    bus.frame_valid = 1'b1;
    bus.frame_data  = f3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_dark("mid_reset");
    end
    chk("sb_empty_at_reset", sbq.size(), 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", bus.frame_ready, 1'b1);
    run_frames(0, f3, 3, cur);

    @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    chk("sb_pop_count", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Monitor: sr_clk rises and latch falls against the queued per-layer expectations.
  initial begin
    logic          p_clk, p_lat;
    logic [N-1:0]  p_en, last_en;
    logic [NN-1:0] col;
    bit            lit, bad_en;
    int            nr, nlat;
    exp_t          e;
    p_clk = 1'b0; p_lat = 1'b0; p_en = '0; last_en = '0; col = '0;
    lit = 1'b0; bad_en = 1'b0; nr = 0; nlat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nr = 0; nlat = 0; col = '0; bad_en = 1'b0; last_en = '0; lit = 1'b0;
      end else begin
        if (bus.sr_clk && !p_clk) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rise_unexpected at cycle %0d: got an sr_clk rise, required none", cyc);
          end else begin
            chk("rise_cycle", cyc, sbq[0].s + S + 2 * S * nr);
`ifdef CUBE_SCAN_BLANK_EN
            chk("shift_layer_en_blank", bus.layer_en, '0);
            chk("shift_oe_n_blank", bus.oe_n, 1'b1);
`else
            chk("shift_layer_en", bus.layer_en, last_en);
            chk("shift_oe_n", bus.oe_n, !lit);
`endif
            col = {col[NN-2:0], bus.sr_data};
            nr++;
          end
        end
        if (bus.sr_latch) nlat++;
`ifdef CUBE_SCAN_BLANK_EN
        if ((bus.sr_clk || bus.sr_latch) && bus.layer_en != '0) bad_en = 1'b1;
`else
        if (bus.layer_en != p_en && !(p_lat && !bus.sr_latch)) bad_en = 1'b1;
`endif
        if (p_lat && !bus.sr_latch) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL latch_unexpected at cycle %0d: got an sr_latch fall, required none", cyc);
          end else begin
            e = sbq.pop_front();
            n_pop++;
            chk("latch_cycle", cyc, e.fall);
            chk("layer_bits", col, e.bits);
            chk("rise_count", nr, NN);
            chk("latch_width", nlat, S);
            chk("latch_layer_en", bus.layer_en, e.en);
            chk("latch_oe_n", bus.oe_n, 1'b0);
            chk("layer_en_steady", bad_en, 1'b0);
            last_en = e.en;
          end
          lit = 1'b1; nr = 0; nlat = 0; bad_en = 1'b0;
        end
      end
      p_clk = bus.sr_clk;
      p_lat = bus.sr_latch;
      p_en  = bus.layer_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no end of test, required finish within time limit", cyc);
    $fatal(1, "watchdog");
  end

endmodule
